// File: rtl/pc_unit.sv
// pc_unit: program-counter unit at the head of instruction fetch.
//
// Holds the PC register and computes the sequential successor PC + STEP.
// Each cycle it picks the next PC from the sequential path, a branch target,
// a jump target or the return-address stack. The priority, highest first, is
// Stall (hold), Ret, Jump, BranchTaken, then sequential.
//
// Optional feature macro: PC_UNIT_RAS_EN
//   defined   : circular return-address stack of RAS_DEPTH entries.
//               Jump & Call pushes PCPlus. Ret pops into PC.
//   undefined : no stack storage is built. Call is ignored. Ret keeps its
//               priority slot but acts as a sequential step.
//               RASEmpty=1, RASFull=0, RetUnderflow=0.
//
// Parameters
//   WIDTH        PC / target width
//   STEP         sequential increment
//   RESET_VECTOR PC value loaded on reset
//   RAS_DEPTH    stack entries (power of two, >= 2)
//
// Ports
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous active-low reset
//   Stall        in   freeze PC and stack this cycle
//   BranchTaken  in   redirect to BranchTarget
//   BranchTarget in   WIDTH
//   Jump         in   redirect to JumpTarget
//   JumpTarget   in   WIDTH
//   Call         in   qualifies Jump as a call (push PCPlus)
//   Ret          in   redirect to stack top and pop
//   PC           out  WIDTH, registered current PC
//   PCPlus       out  WIDTH, PC + STEP (wraps, carry discarded)
//   RASEmpty     out  stack holds no entries
//   RASFull      out  stack holds RAS_DEPTH entries
//   RetUnderflow out  one-cycle pulse after a Ret accepted while empty

module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] STEP         = WIDTH'(4),
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic             Ret,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus,
    output logic             RASEmpty,
    output logic             RASFull,
    output logic             RetUnderflow
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus;

    // Same width on both operands, so the carry out is simply dropped.
    assign pc_plus = pc_q + STEP;

`ifdef PC_UNIT_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    // ptr_q is the next free slot. The top of the stack is at ptr_q - 1.
    // A push when full lands on the oldest entry, which gives the circular
    // overwrite without any extra logic.
    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             underflow_q;
    logic             underflow_d;
    logic             push;
    logic             pop;
    logic             ras_empty;
    logic [WIDTH-1:0] ras_top;

    assign ras_empty = (cnt_q == '0);
    assign ras_top   = ras_mem_q[ptr_q - 1'b1];

    always_comb begin
        pc_d        = pc_q;
        push        = 1'b0;
        pop         = 1'b0;
        underflow_d = 1'b0;
        if (!Stall) begin
            if (Ret) begin
                // A Call in the same cycle is dropped: Ret wins outright.
                if (!ras_empty) begin
                    pc_d = ras_top;
                    pop  = 1'b1;
                end else begin
                    pc_d        = pc_plus;
                    underflow_d = 1'b1;
                end
            end else if (Jump) begin
                pc_d = JumpTarget;
                push = Call;
            end else if (BranchTaken) begin
                pc_d = BranchTarget;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q        <= RESET_VECTOR;
            ptr_q       <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage carries no reset; an entry is never read before a push
    // has written it, because the count gates every pop.
    always_ff @(posedge Clk) begin
        if (push) begin
            ras_mem_q[ptr_q] <= pc_plus;
        end
    end

    assign RASEmpty     = ras_empty;
    assign RASFull      = (cnt_q == CNT_MAX);
    assign RetUnderflow = underflow_q;

`else
    // Ret still outranks Jump and BranchTaken, but it only steps sequentially.
    always_comb begin
        pc_d = pc_q;
        if (!Stall) begin
            if (Ret) begin
                pc_d = pc_plus;
            end else if (Jump) begin
                pc_d = JumpTarget;
            end else if (BranchTaken) begin
                pc_d = BranchTarget;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Call and RAS_DEPTH have no function in this build.
    logic unused_cfg;
    assign unused_cfg = Call ^ (RAS_DEPTH == 0);

    assign RASEmpty     = 1'b1;
    assign RASFull      = 1'b0;
    assign RetUnderflow = 1'b0;
`endif

    assign PC     = pc_q;
    assign PCPlus = pc_plus;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Call;
    logic        Ret;
    logic [31:0] PC;
    logic [31:0] PCPlus;
    logic        RASEmpty;
    logic        RASFull;
    logic        RetUnderflow;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit #(
        .WIDTH(32), .STEP(32'd4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Call(Call), .Ret(Ret),
        .PC(PC), .PCPlus(PCPlus), .RASEmpty(RASEmpty), .RASFull(RASFull),
        .RetUnderflow(RetUnderflow)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        Stall = 0; BranchTaken = 0; Jump = 0; Call = 0; Ret = 0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b0;
        #2;
        n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h0); end
        n_checks++; if (PCPlus !== 32'h4) begin n_fail++; $display("FAIL reset_pcplus: got %h expected %h", PCPlus, 32'h4); end
        n_checks++; if (RASEmpty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", RASEmpty); end
        n_checks++; if (RASFull !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", RASFull); end
        n_checks++; if (RetUnderflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b expected 0", RetUnderflow); end
        tick();
        Reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (PC !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, PC, 32'(i * 4)); end
        end
        #2;
        Reset = 1'b0;
        #1;
        n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h expected %h", PC, 32'h0); end
        #1;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        Jump = 1; JumpTarget = 32'h10;
        tick();
        n_checks++; if (PC !== 32'h10) begin n_fail++; $display("FAIL jump_pc: got %h expected %h", PC, 32'h10); end
        BranchTaken = 1; BranchTarget = 32'h100; Jump = 1; JumpTarget = 32'h200; Stall = 1;
        tick();
        n_checks++; if (PC !== 32'h10) begin n_fail++; $display("FAIL stall_pc: got %h expected %h", PC, 32'h10); end
        n_checks++; if (PCPlus !== 32'h14) begin n_fail++; $display("FAIL stall_pcplus: got %h expected %h", PCPlus, 32'h14); end
        Stall = 0;
        tick();
        n_checks++; if (PC !== 32'h200) begin n_fail++; $display("FAIL jump_over_branch: got %h expected %h", PC, 32'h200); end
        // Ret beats Jump and Branch; stack is empty so it steps sequentially.
        Ret = 1;
        tick();
        n_checks++; if (PC !== 32'h204) begin n_fail++; $display("FAIL ret_over_jump: got %h expected %h", PC, 32'h204); end
        n_checks++; if (RetUnderflow !== RAS_ON) begin n_fail++; $display("FAIL underflow_pulse: got %b expected %b", RetUnderflow, RAS_ON); end
        idle_inputs();
        tick();
        n_checks++; if (PC !== 32'h208) begin n_fail++; $display("FAIL seq_after_ret: got %h expected %h", PC, 32'h208); end
        n_checks++; if (RetUnderflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b expected 0", RetUnderflow); end
        Ret = 1; Stall = 1;
        tick();
        n_checks++; if (PC !== 32'h208) begin n_fail++; $display("FAIL stalled_ret_pc: got %h expected %h", PC, 32'h208); end
        n_checks++; if (RetUnderflow !== 1'b0) begin n_fail++; $display("FAIL stalled_ret_underflow: got %b expected 0", RetUnderflow); end
        idle_inputs();
        BranchTaken = 1; BranchTarget = 32'h100;
        tick();
        n_checks++; if (PC !== 32'h100) begin n_fail++; $display("FAIL branch_pc: got %h expected %h", PC, 32'h100); end
        idle_inputs();
    endtask

    task automatic test_call_ret();
        do_reset();
        Jump = 1; JumpTarget = 32'h20;
        tick();
        Call = 1; JumpTarget = 32'h400;
        tick();
        n_checks++; if (PC !== 32'h400) begin n_fail++; $display("FAIL call_pc: got %h expected %h", PC, 32'h400); end
        n_checks++; if (RASEmpty !== !RAS_ON) begin n_fail++; $display("FAIL call_empty: got %b expected %b", RASEmpty, !RAS_ON); end
        idle_inputs();
        Ret = 1;
        tick();
        n_checks++; if (PC !== (RAS_ON ? 32'h24 : 32'h404)) begin n_fail++; $display("FAIL ret_pc: got %h expected %h", PC, RAS_ON ? 32'h24 : 32'h404); end
        n_checks++; if (RASEmpty !== 1'b1) begin n_fail++; $display("FAIL ret_empty: got %b expected 1", RASEmpty); end
        n_checks++; if (RetUnderflow !== 1'b0) begin n_fail++; $display("FAIL ret_no_underflow: got %b expected 0", RetUnderflow); end
        // Call from the returned address, then Ret together with Jump & Call.
        idle_inputs();
        Jump = 1; Call = 1; JumpTarget = 32'h500;
        tick();
        n_checks++; if (PC !== 32'h500) begin n_fail++; $display("FAIL call2_pc: got %h expected %h", PC, 32'h500); end
        Ret = 1; JumpTarget = 32'h600;
        tick();
        n_checks++; if (PC !== (RAS_ON ? 32'h28 : 32'h504)) begin n_fail++; $display("FAIL ret_call_pc: got %h expected %h", PC, RAS_ON ? 32'h28 : 32'h504); end
        n_checks++; if (RASEmpty !== 1'b1) begin n_fail++; $display("FAIL ret_call_empty: got %b expected 1", RASEmpty); end
        idle_inputs();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            Jump = 1; Call = 1; JumpTarget = 32'((i + 1) * 32'h100);
            tick();
            n_checks++;
            if (PC !== 32'((i + 1) * 32'h100)) begin n_fail++; $display("FAIL nest_pc[%0d]: got %h expected %h", i, PC, 32'((i + 1) * 32'h100)); end
            n_checks++;
            if (RASFull !== (RAS_ON && i >= 3)) begin n_fail++; $display("FAIL nest_full[%0d]: got %b expected %b", i, RASFull, RAS_ON && i >= 3); end
        end
        idle_inputs();
        Ret = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            exp_pc = RAS_ON ? 32'(32'h404 - j * 32'h100) : 32'(32'h504 + j * 4);
            n_checks++;
            if (PC !== exp_pc) begin n_fail++; $display("FAIL ret_pc[%0d]: got %h expected %h", j, PC, exp_pc); end
            n_checks++;
            if (RetUnderflow !== 1'b0) begin n_fail++; $display("FAIL ret_underflow[%0d]: got %b expected 0", j, RetUnderflow); end
        end
        tick();
        exp_pc = RAS_ON ? 32'h108 : 32'h514;
        n_checks++; if (PC !== exp_pc) begin n_fail++; $display("FAIL ret5_pc: got %h expected %h", PC, exp_pc); end
        n_checks++; if (RetUnderflow !== RAS_ON) begin n_fail++; $display("FAIL ret5_underflow: got %b expected %b", RetUnderflow, RAS_ON); end
        n_checks++; if (RASEmpty !== 1'b1) begin n_fail++; $display("FAIL ret5_empty: got %b expected 1", RASEmpty); end
        idle_inputs();
        tick();
        n_checks++; if (RetUnderflow !== 1'b0) begin n_fail++; $display("FAIL ret5_pulse_end: got %b expected 0", RetUnderflow); end
    endtask

    task automatic test_reset_mid_call();
        do_reset();
        Jump = 1; Call = 1; JumpTarget = 32'h300;
        tick();
        tick();
        n_checks++; if (RASEmpty !== !RAS_ON) begin n_fail++; $display("FAIL midcall_empty: got %b expected %b", RASEmpty, !RAS_ON); end
        idle_inputs();
        #2;
        Reset = 1'b0;
        #1;
        n_checks++; if (RASEmpty !== 1'b1) begin n_fail++; $display("FAIL midcall_reset_empty: got %b expected 1", RASEmpty); end
        n_checks++; if (RASFull !== 1'b0) begin n_fail++; $display("FAIL midcall_reset_full: got %b expected 0", RASFull); end
        Reset = 1'b1;
        Ret = 1;
        tick();
        n_checks++; if (PC !== 32'h4) begin n_fail++; $display("FAIL midcall_ret_pc: got %h expected %h", PC, 32'h4); end
        n_checks++; if (RetUnderflow !== RAS_ON) begin n_fail++; $display("FAIL midcall_ret_underflow: got %b expected %b", RetUnderflow, RAS_ON); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        tick();
        n_checks++; if (PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_jump_pc: got %h expected %h", PC, 32'hFFFF_FFFC); end
        n_checks++; if (PCPlus !== 32'h0) begin n_fail++; $display("FAIL wrap_pcplus: got %h expected %h", PCPlus, 32'h0); end
        idle_inputs();
        tick();
        n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", PC, 32'h0); end
        n_checks++; if (RetUnderflow !== 1'b0) begin n_fail++; $display("FAIL wrap_flag: got %b expected 0", RetUnderflow); end
        n_checks++; if (PCPlus !== 32'h4) begin n_fail++; $display("FAIL wrap_pcplus2: got %h expected %h", PCPlus, 32'h4); end
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        #3;
        test_reset();
        test_priority();
        test_call_ret();
        test_overflow();
        test_reset_mid_call();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: successor to the fixed `PC + 4` incrementor. It holds the PC register and computes the sequential next PC. It selects among sequential, branch, jump and return targets, and honours pipeline stall. It also keeps a small circular return-address stack (RAS) for call/return. It sits at the head of the instruction-fetch stage and drives the instruction-memory address.

## Interface
- `WIDTH`, 32: PC / target width in bits.
- `STEP`, 4: sequential increment added to PC.
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: return-stack entries; power of two, ≥2.

- `Clk`  in  1: single clock; all state updates on rising edge.
- `Reset`  in  1: reset is asynchronous and active-low.
- `Stall`  in  1: hold PC and RAS unchanged this cycle.
- `BranchTaken`  in  1: redirect to `BranchTarget`.
- `BranchTarget`  in  WIDTH: branch destination.
- `Jump`  in  1: redirect to `JumpTarget`.
- `JumpTarget`  in  WIDTH: jump destination.
- `Call`  in  1: qualifies `Jump` as a call; push `PCPlus`.
- `Ret`  in  1: redirect to RAS top; pop.
- `PC`  out  WIDTH: current PC (registered).
- `PCPlus`  out  WIDTH: `PC + STEP` (combinational from `PC`).
- `RASEmpty`  out  1: RAS holds zero entries.
- `RASFull`  out  1: RAS holds `RAS_DEPTH` entries.
- `RetUnderflow`  out  1: registered one-cycle pulse; `Ret` accepted while empty.

## Operation
- Next-PC priority, highest first: `Stall` (hold) > `Ret` > `Jump` > `BranchTaken` > sequential (`PCPlus`).
- Arithmetic: `PCPlus = (PC + STEP) mod 2^WIDTH`. Carry is discarded, so PC wraps from max to low addresses silently. Targets are used verbatim with no alignment masking.
- `Call` without `Jump` is ignored.
- `Jump` & `Call` (no `Ret`, no `Stall`):
  - Push `PCPlus`.
  - PC ← `JumpTarget`.
- `Ret` with RAS non-empty:
  - PC ← top entry.
  - Pop.
- `Ret` with RAS empty:
  - PC ← `PCPlus`.
  - RAS unchanged.
  - `RetUnderflow` = 1 for the following cycle.
- `Ret` & `Call` in the same cycle: treated as `Ret` only; the push is dropped.
- Push when full: circular overwrite of the oldest entry. Count stays `RAS_DEPTH` and no error is flagged.
- RAS state:
  - A `log2(RAS_DEPTH)`-bit top pointer.
  - A count of 0..`RAS_DEPTH`.
  - Entries of WIDTH bits.
- `RASEmpty` and `RASFull` are decoded from the count.
- `Stall` freezes the PC and all RAS state. `RetUnderflow` is not asserted for a stalled `Ret`.

## Timing
- Reset (asynchronous assert, `Reset`=0):
  - `PC` = `RESET_VECTOR`.
  - `PCPlus` = `RESET_VECTOR + STEP`.
  - Count = 0, pointer = 0.
  - `RASEmpty` = 1, `RASFull` = 0, `RetUnderflow` = 0.
  - RAS entries need not be cleared.
- Reset deassertion: first update at the first rising `Clk` with `Reset`=1.
- Reset mid-call/return: all in-flight stack content is discarded (count = 0).
- Redirect latency: control inputs sampled at edge N take effect in `PC` after edge N; one cycle.
- `PCPlus` follows `PC` combinationally, with zero latency.
- Push/pop latency: stack effect is visible at the same edge as the PC update. A `Ret` in cycle N+1 returns the address pushed by the `Call` in cycle N.

## Configuration
- Macro: `PC_UNIT_RAS_EN`.
- Defined: RAS is present, with behaviour as above.
- Undefined:
  - No RAS storage is built.
  - `Call` is ignored, and `Jump`&`Call` acts as a plain `Jump`.
  - `Ret` acts as sequential (PC ← `PCPlus`) and keeps its priority slot, so `Ret` still overrides `Jump`/`BranchTaken`.
  - Outputs tied: `RASEmpty`=1, `RASFull`=0, `RetUnderflow`=0.
  - `RAS_DEPTH` is unused.

## Test plan
- Reset and sequential run (`RESET_VECTOR`=0x0, `STEP`=4):
  - Stimulus: release reset, idle 3 cycles.
  - Response: `PC` = 0x0, 0x4, 0x8, 0xC.
  - Stimulus: `Reset`=0 asynchronously mid-cycle.
  - Response: `PC`=0x0 immediately.
- Priority:
  - Stimulus: at `PC`=0x10, assert `BranchTaken`(0x100) and `Jump`(0x200) together.
  - Response: `PC`=0x200.
  - Stimulus: add `Stall`.
  - Response: `PC` stays 0x10.
- Call/return:
  - Stimulus: at `PC`=0x20, `Jump`&`Call` to 0x400; next cycle `Ret`.
  - Response: `PC`=0x400, then 0x24, and `RASEmpty`=1.
- RAS overflow (`RAS_DEPTH`=4):
  - Stimulus: 5 nested calls from 0x0, 0x100, 0x200, 0x300, 0x400, then 5 `Ret`s.
  - Response: returns go to 0x404, 0x304, 0x204, 0x104.
  - Response: the 5th `Ret` gives `PCPlus` and a one-cycle `RetUnderflow`.
  - Response: `RASFull`=1 after the 4th push.
- Wrap-around (`WIDTH`=32):
  - Stimulus: `Jump` to 0xFFFFFFFC, then idle.
  - Response: next `PC`=0x00000000, with no flag.
- Macro off:
  - Stimulus: the same call/return sequence.
  - Response: `PC`=0x400, then 0x404, with `RASEmpty`=1 throughout.
